// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_pkg : opcodes, flag indices and issue-FSM encoding shared by the  |
// |           ALU, the decoder and alu_issue_ctrl.   Revision: 1.0       |
// +----------------------------------------------------------------------+
package cpu_pkg;

    localparam int DATA_W  = 16;
    localparam int INSTR_W = 16;
    localparam int OPC_W   = 6;
    localparam int FLAG_W  = 4;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_O = 3;

    localparam logic [OPC_W-1:0] OP_NOP  = 6'h00;
    localparam logic [OPC_W-1:0] OP_ADD  = 6'h0A;
    localparam logic [OPC_W-1:0] OP_SUB  = 6'h0B;
    localparam logic [OPC_W-1:0] OP_AND  = 6'h0C;
    localparam logic [OPC_W-1:0] OP_OR   = 6'h0D;
    localparam logic [OPC_W-1:0] OP_XOR  = 6'h0E;
    localparam logic [OPC_W-1:0] OP_NOT  = 6'h0F;
    localparam logic [OPC_W-1:0] OP_MOV  = 6'h10;
    localparam logic [OPC_W-1:0] OP_MUL  = 6'h11;
    localparam logic [OPC_W-1:0] OP_DIV  = 6'h12;
    localparam logic [OPC_W-1:0] OP_MOD  = 6'h13;
    localparam logic [OPC_W-1:0] OP_INC  = 6'h14;
    localparam logic [OPC_W-1:0] OP_DEC  = 6'h15;
    localparam logic [OPC_W-1:0] OP_SHL  = 6'h16;
    localparam logic [OPC_W-1:0] OP_SHR  = 6'h17;
    localparam logic [OPC_W-1:0] OP_CMP  = 6'h18;
    localparam logic [OPC_W-1:0] OP_TST  = 6'h19;
    localparam logic [OPC_W-1:0] OP_NEG  = 6'h1A;
    localparam logic [OPC_W-1:0] OP_SWAP = 6'h1B;

    localparam logic [OPC_W-1:0] OP_FIRST = OP_ADD;
    localparam logic [OPC_W-1:0] OP_LAST  = OP_SWAP;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    function automatic logic op_is_legal(input logic [OPC_W-1:0] op);
        return (op >= OP_FIRST) && (op <= OP_LAST);
    endfunction

    function automatic logic op_is_divide(input logic [OPC_W-1:0] op);
        return (op == OP_DIV) || (op == OP_MOD);
    endfunction

    // Compare-style ops set flags but never write a register
    function automatic logic op_is_flag_only(input logic [OPC_W-1:0] op);
        return (op == OP_CMP) || (op == OP_TST);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_issue_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_issue_ctrl_if : instruction-in and result-out handshakes.        |
// |                     Revision: 1.0                                    |
// +----------------------------------------------------------------------+
interface alu_issue_ctrl_if;

    logic                         in_valid;
    logic                         in_ready;
    logic [cpu_pkg::INSTR_W-1:0]  instr;
    logic                         res_valid;
    logic                         res_ready;
    logic [cpu_pkg::DATA_W-1:0]   res_data;
    logic                         res_err;

    modport master (
        output in_valid, instr, res_ready,
        input  in_ready, res_valid, res_data, res_err
    );

    modport slave (
        input  in_valid, instr, res_ready,
        output in_ready, res_valid, res_data, res_err
    );

endinterface
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_issue_ctrl : one-at-a-time issue of X/Y-register ops to an        |
// |                  external ALU with result handshake. Revision: 1.0   |
// +----------------------------------------------------------------------+
module alu_issue_ctrl
    import cpu_pkg::*;
#(
    parameter int IMM_W = 9
)
(
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    alu_issue_ctrl_if.slave           bus,
    output logic [DATA_W-1:0]         alu_a,
    output logic [DATA_W-1:0]         alu_b,
    output logic [OPC_W-1:0]          alu_opcode,
    output logic                      alu_store,
    input  wire logic [DATA_W-1:0]    alu_out,
    input  wire logic [FLAG_W-1:0]    alu_flags,
    output logic [FLAG_W-1:0]         flags,
    output logic [DATA_W-1:0]         reg_x,
    output logic [DATA_W-1:0]         reg_y
);

    state_t               state_q, state_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic [DATA_W-1:0]    reg_x_q, reg_x_d;
    logic [DATA_W-1:0]    reg_y_q, reg_y_d;
    logic [FLAG_W-1:0]    flags_q, flags_d;
    logic [DATA_W-1:0]    res_data_q, res_data_d;
    logic                 res_err_q, res_err_d;

    logic [OPC_W-1:0]     w_opc;
    logic                 w_sel;
    logic [IMM_W-1:0]     w_imm;
    logic                 w_err;

    assign w_opc = instr_q[INSTR_W-1 -: OPC_W];
    assign w_sel = instr_q[IMM_W];
    assign w_imm = instr_q[IMM_W-1:0];
    assign w_err = !op_is_legal(w_opc) || (op_is_divide(w_opc) && (w_imm == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            instr_q    <= '0;
            reg_x_q    <= '0;
            reg_y_q    <= '0;
            flags_q    <= '0;
            res_data_q <= '0;
            res_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            reg_x_q    <= reg_x_d;
            reg_y_q    <= reg_y_d;
            flags_q    <= flags_d;
            res_data_q <= res_data_d;
            res_err_q  <= res_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        reg_x_d    = reg_x_q;
        reg_y_d    = reg_y_q;
        flags_d    = flags_q;
        res_data_d = res_data_q;
        res_err_d  = res_err_q;
        alu_a      = w_sel ? reg_y_q : reg_x_q;
        alu_b      = {{(DATA_W-IMM_W){1'b0}}, w_imm};
        // Outside a legal EXEC the ALU just passes A, keeping its outputs defined
        alu_store  = 1'b1;
        alu_opcode = OP_NOP;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    instr_d = bus.instr;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_WB;
                if (w_err) begin
                    res_data_d = '0;
                    res_err_d  = 1'b1;
                end else begin
                    alu_store  = 1'b0;
                    alu_opcode = w_opc;
                    res_data_d = alu_out;
                    res_err_d  = 1'b0;
                    flags_d    = alu_flags;
                    if (!op_is_flag_only(w_opc)) begin
                        if (w_sel) reg_y_d = alu_out;
                        else       reg_x_d = alu_out;
                    end
                end
            end
            ST_WB: begin
                if (bus.res_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.res_valid = (state_q == ST_WB);
    assign bus.res_data  = res_data_q;
    assign bus.res_err   = res_err_q;
    assign flags         = flags_q;
    assign reg_x         = reg_x_q;
    assign reg_y         = reg_y_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// Scoreboard bench for alu_issue_ctrl: a behavioural ALU drives the DUT's ALU
// inputs, and a register/flag model predicts every result handshake.
module tb_alu_issue_ctrl;
    import cpu_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_issue_ctrl_if bus ();

    logic [15:0] alu_a, alu_b, alu_out, reg_x, reg_y;
    logic [5:0]  alu_opcode;
    logic        alu_store;
    logic [3:0]  alu_flags, flags;

    alu_issue_ctrl #(.IMM_W(9)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_store  (alu_store),
        .alu_out    (alu_out),
        .alu_flags  (alu_flags),
        .flags      (flags),
        .reg_x      (reg_x),
        .reg_y      (reg_y)
    );

    typedef struct packed { logic [15:0] r; logic [3:0] f; } alu_res_t;

    // INC/DEC report unsigned wrap in both C and O
    function automatic alu_res_t alu_model(input logic [5:0] op, input logic store,
                                           input logic [15:0] a, input logic [15:0] b);
        logic [16:0] w;
        logic [31:0] p;
        logic [15:0] r;
        logic        c, o;
        alu_res_t    res;
        w = '0; p = '0; r = a; c = 1'b0; o = 1'b0;
        if (!store) begin
            case (op)
                OP_ADD:         begin w = {1'b0, a} + {1'b0, b}; r = w[15:0]; c = w[16];
                                      o = (a[15] == b[15]) && (r[15] != a[15]); end
                OP_SUB, OP_CMP: begin r = a - b; c = (a < b);
                                      o = (a[15] != b[15]) && (r[15] != a[15]); end
                OP_AND, OP_TST: r = a & b;
                OP_OR:          r = a | b;
                OP_XOR:         r = a ^ b;
                OP_NOT:         r = ~a;
                OP_MOV:         r = b;
                OP_MUL:         begin p = a * b; r = p[15:0]; c = |p[31:16]; end
                OP_DIV:         r = (b == 16'd0) ? 16'hFFFF : a / b;
                OP_MOD:         r = (b == 16'd0) ? a : a % b;
                OP_INC:         begin r = a + 16'd1; c = (a == 16'hFFFF); o = c; end
                OP_DEC:         begin r = a - 16'd1; c = (a == 16'h0000); o = c; end
                OP_SHL:         r = a << b[3:0];
                OP_SHR:         r = a >> b[3:0];
                OP_NEG:         begin r = 16'd0 - a; c = (a != 16'd0); end
                OP_SWAP:        r = {a[7:0], a[15:8]};
                default:        r = a;
            endcase
        end
        res.r = r;
        res.f = '0;
        res.f[FLAG_Z] = (r == 16'd0);
        res.f[FLAG_N] = r[15];
        res.f[FLAG_C] = c;
        res.f[FLAG_O] = o;
        return res;
    endfunction

    alu_res_t alu_now;
    assign alu_now   = alu_model(alu_opcode, alu_store, alu_a, alu_b);
    assign alu_out   = alu_now.r;
    assign alu_flags = alu_now.f;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    typedef struct {
        logic [15:0] data;
        logic        err;
        logic [15:0] rx, ry;
        logic [3:0]  fl;
        logic        store;
        logic [5:0]  opc;
        logic [15:0] a, b;
        int          acc_cyc;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] m_reg [2];
    logic [3:0]  m_flags;

    function automatic void model_reset();
        m_reg[0] = '0;
        m_reg[1] = '0;
        m_flags  = '0;
        sb.delete();
    endfunction

    function automatic void model_issue(input logic [15:0] ins, input int c);
        exp_t     e;
        alu_res_t r;
        logic [5:0] opc = ins[15:10];
        int         sel = int'(ins[9]);
        logic [8:0] imm = ins[8:0];
        logic       err = !(opc inside {[6'h0A:6'h1B]}) ||
                          ((opc == 6'h12 || opc == 6'h13) && imm == 9'd0);
        e.acc_cyc = c;
        e.a       = m_reg[sel];
        e.b       = {7'd0, imm};
        if (err) begin
            e.store = 1'b1; e.opc = 6'h00; e.data = 16'd0; e.err = 1'b1;
        end else begin
            r = alu_model(opc, 1'b0, e.a, e.b);
            e.store = 1'b0; e.opc = opc; e.data = r.r; e.err = 1'b0;
            m_flags = r.f;
            if (opc != 6'h18 && opc != 6'h19) m_reg[sel] = r.r;
        end
        e.rx = m_reg[0];
        e.ry = m_reg[1];
        e.fl = m_flags;
        sb.push_back(e);
    endfunction

    // Monitor: per-cycle ALU-control checks and result pops on the handshake
    initial begin
        logic        hold = 1'b0;
        logic        seen = 1'b0;
        logic [15:0] hold_data = '0;
        logic        hold_err = 1'b0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold = 1'b0;
                seen = 1'b0;
            end else begin
                if (bus.in_ready || bus.res_valid) begin
                    chk("idle_wb_alu_store", alu_store, 1);
                    chk("idle_wb_alu_opcode", alu_opcode, 0);
                end else if (sb.size() != 1) begin
                    chk("exec_scoreboard_depth", sb.size(), 1);
                end else begin
                    chk("exec_alu_store", alu_store, sb[0].store);
                    chk("exec_alu_opcode", alu_opcode, sb[0].opc);
                    chk("exec_alu_a", alu_a, sb[0].a);
                    chk("exec_alu_b", alu_b, sb[0].b);
                end
                if (bus.res_valid) begin
                    chk("wb_in_ready", bus.in_ready, 0);
                    if (!seen && sb.size() > 0) chk("latency", cyc - sb[0].acc_cyc, 2);
                    seen = 1'b1;
                    if (hold) begin
                        chk("hold_res_data", bus.res_data, hold_data);
                        chk("hold_res_err", bus.res_err, hold_err);
                    end
                    if (bus.res_ready) begin
                        if (sb.size() == 0) begin
                            chk("unexpected_result", sb.size(), 1);
                        end else begin
                            e = sb.pop_front();
                            chk("res_data", bus.res_data, e.data);
                            chk("res_err", bus.res_err, e.err);
                            chk("reg_x", reg_x, e.rx);
                            chk("reg_y", reg_y, e.ry);
                            chk("flags", flags, e.fl);
                        end
                        hold = 1'b0;
                        seen = 1'b0;
                    end else begin
                        hold      = 1'b1;
                        hold_data = bus.res_data;
                        hold_err  = bus.res_err;
                    end
                end else begin
                    if (hold) chk("hold_res_valid", bus.res_valid, 1);
                    hold = 1'b0;
                end
            end
        end
    end

    int rr_mode = 2;  // 0 random, 1 low, 2 high
    initial begin
        bus.res_ready = 1'b0;
        forever begin
            @(posedge clk); #2;
            case (rr_mode)
                0:       bus.res_ready = ($urandom_range(0, 3) != 0);
                1:       bus.res_ready = 1'b0;
                default: bus.res_ready = 1'b1;
            endcase
        end
    end

    // Junk in_valid is offered only while busy; it must be ignored
    task automatic issue(input logic [15:0] ins);
        int n = 0;
        forever begin
            @(posedge clk); #2;
            if (bus.in_ready) begin
                bus.in_valid = 1'b1;
                bus.instr    = ins;
                model_issue(ins, cyc);
                break;
            end
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.instr    = 16'($urandom);
            n++;
            if (n > 100) begin
                chk("issue_timeout", n, 0);
                bus.in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk); #2;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        forever begin
            @(posedge clk); #2;
            if (sb.size() == 0 && bus.in_ready) break;
            n++;
            if (n > 200) begin
                chk("done_timeout", n, 0);
                break;
            end
        end
    endtask

    task automatic wait_res_valid();
        int n = 0;
        forever begin
            @(posedge clk); #2;
            if (bus.res_valid) break;
            n++;
            if (n > 50) begin
                chk("res_valid_timeout", n, 0);
                break;
            end
        end
    endtask

    function automatic logic [15:0] rand_instr();
        logic [5:0] opc;
        logic [8:0] imm;
        opc = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'($urandom_range(8, 29));
        imm = ($urandom_range(0, 5) == 0) ? 9'd0 : 9'($urandom);
        return {opc, 1'($urandom_range(0, 1)), imm};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.instr    = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_reg_x", reg_x, 0);
        chk("rst_reg_y", reg_y, 0);
        chk("rst_flags", flags, 0);
        chk("rst_res_data", bus.res_data, 0);

        issue(16'h4005); wait_done();                       // MOV X,#5
        chk("mov_reg_x", reg_x, 16'h0005);
        chk("mov_res_data", bus.res_data, 16'h0005);
        chk("mov_flags", flags, 4'b0000);

        issue(16'h4000); issue(16'h5400); wait_done();      // MOV X,#0 ; DEC X
        chk("dec_res_data", bus.res_data, 16'hFFFF);
        chk("dec_flags", flags, 4'b1110);
        issue(16'h5000); wait_done();                       // INC X
        chk("inc_res_data", bus.res_data, 16'h0000);
        chk("inc_flags", flags, 4'b1101);

        issue(16'h4203); issue(16'h6203); wait_done();      // MOV Y,#3 ; CMP Y,#3
        chk("cmp_flags", flags, 4'b0001);
        chk("cmp_res_data", bus.res_data, 16'h0000);
        chk("cmp_reg_y", reg_y, 16'h0003);

        issue(16'h4800); wait_done();                       // DIV X,#0
        chk("div0_res_err", bus.res_err, 1);
        chk("div0_reg_x", reg_x, 16'h0000);
        chk("div0_flags", flags, 4'b0001);
        issue(16'hFC05); wait_done();                       // opcode 0x3F
        chk("ill_res_err", bus.res_err, 1);
        chk("ill_res_data", bus.res_data, 16'h0000);
        chk("ill_flags", flags, 4'b0001);

        rr_mode = 1;
        issue(16'h4007);                                    // MOV X,#7 under back-pressure
        wait_res_valid();
        repeat (5) begin
            bus.in_valid = 1'b1;
            bus.instr    = 16'h4011;
            @(posedge clk); #2;
            chk("bp_res_valid", bus.res_valid, 1);
            chk("bp_res_data", bus.res_data, 16'h0007);
            chk("bp_in_ready", bus.in_ready, 0);
        end
        bus.in_valid = 1'b0;
        rr_mode = 2;
        wait_done();
        chk("bp_reg_x", reg_x, 16'h0007);

        rr_mode = 1;
        issue(16'h4209);                                    // MOV Y,#9, reset in WB
        wait_res_valid();
        #1 rst_n = 1'b0;
        #1;
        chk("wbrst_res_valid", bus.res_valid, 0);
        chk("wbrst_reg_x", reg_x, 0);
        chk("wbrst_reg_y", reg_y, 0);
        chk("wbrst_flags", flags, 0);
        chk("wbrst_res_data", bus.res_data, 0);
        chk("wbrst_res_err", bus.res_err, 0);
        chk("wbrst_in_ready", bus.in_ready, 1);
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        rr_mode = 2;
        issue(16'h4005); wait_done();
        chk("post_rst_reg_x", reg_x, 16'h0005);
        chk("post_rst_res_data", bus.res_data, 16'h0005);
        chk("post_rst_flags", flags, 4'b0000);
        chk("post_rst_reg_y", reg_y, 16'h0000);

        rr_mode = 0;
        repeat (150) issue(rand_instr());
        wait_done();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
